aes_round_sched: RTL

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_rcon_gen.sv | 16 +
 rtl/aes_round_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg -- shared constants for the AES-128 round scheduler.
//   NR        : number of AES-128 rounds
//   ST_*      : scheduler state encodings (IDLE, KEXP, RUN, DONE)
//   RCON_TAB  : round constants for key-schedule steps 1..10, entry 1 in the low byte
//   rcon_of() : table lookup, returns 8'h00 for indices outside 1..10
package aes_pkg;

  localparam int NR = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_KEXP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [79:0] RCON_TAB = {8'h36, 8'h1B, 8'h80, 8'h40, 8'h20,
                                      8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    int pos;
    pos = 32'(idx) - 32'd1;
    if ((idx >= 4'd1) && (idx <= 4'd10)) begin
      rcon_of = RCON_TAB[pos*8 +: 8];
    end else begin
      rcon_of = 8'h00;
    end
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen -- combinational round-constant lookup.
//   ks_idx : in  4  key-schedule step index (1..10 meaningful)
//   rcon   : out 8  round constant for ks_idx, 8'h00 outside 1..10
import aes_pkg::*;

module aes_rcon_gen (
  input  logic [3:0] ks_idx,
  output logic [7:0] rcon
);

  // Table lookup from the shared package.
  always_comb begin
    rcon = rcon_of(ks_idx);
  end

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched -- control FSM sequencing an iterative AES-128 datapath.
// Runs the key expansion (KEXP), then per block one load cycle, NR round
// cycles (RUN) and a hold cycle (DONE) until the consumer takes the result.
//   clk, rst             : clock, synchronous active-high reset
//   key_start            : start key expansion (only honoured in IDLE)
//   in_valid, in_decrypt : offered block and its mode
//   in_ready             : block accepted this cycle when in_valid is high
//   out_ready, out_valid : result handshake
//   key_ok               : expanded key valid
//   ks_en, ks_idx, rcon  : key-schedule step strobe, index, round constant
//   st_load, rnd_en      : load-state strobe, apply-round strobe
//   rk_idx, rnd_last     : round-key select, final-round flag
//   dec                  : latched mode of the block in flight
//   blk_cnt              : saturating count of completed blocks
import aes_pkg::*;

module aes_round_sched #(
  parameter int NR   = aes_pkg::NR,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_start,
  input  logic            in_valid,
  input  logic            in_decrypt,
  output logic            in_ready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            key_ok,
  output logic            ks_en,
  output logic [3:0]      ks_idx,
  output logic [7:0]      rcon,
  output logic            st_load,
  output logic            rnd_en,
  output logic [3:0]      rk_idx,
  output logic            rnd_last,
  output logic            dec,
  output logic [CNTW-1:0] blk_cnt
);

  localparam logic [3:0] NR_L = 4'(NR);

  logic [1:0]      state_r;
  logic [3:0]      cnt_r;      // shared step counter for KEXP and RUN, runs 1..NR
  logic            key_ok_r;
  logic            dec_r;
  logic [CNTW-1:0] blk_cnt_r;
  logic            accept;
  logic [7:0]      rcon_lut;

  // Fed from the counter rather than ks_idx so the lookup stays off the output decode path.
  aes_rcon_gen u_rcon (
    .ks_idx (cnt_r),
    .rcon   (rcon_lut)
  );

  assign key_ok  = key_ok_r;
  assign dec     = dec_r;
  assign blk_cnt = blk_cnt_r;

  // Handshake: key_start in the same cycle wins over a block offer.
  always_comb begin
    in_ready = (state_r == ST_IDLE) && key_ok_r && !key_start;
    accept   = in_ready && in_valid;
  end

  // Datapath strobes and indices, all zero unless their enable is active.
  always_comb begin
    ks_en     = 1'b0;
    ks_idx    = 4'd0;
    rcon      = 8'h00;
    st_load   = 1'b0;
    rnd_en    = 1'b0;
    rk_idx    = 4'd0;
    rnd_last  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          st_load = 1'b1;
          rk_idx  = in_decrypt ? NR_L : 4'd0;
        end else begin
          st_load = 1'b0;
        end
      end
      ST_KEXP: begin
        ks_en  = 1'b1;
        ks_idx = cnt_r;
        rcon   = rcon_lut;
      end
      ST_RUN: begin
        rnd_en   = 1'b1;
        // Decrypt walks the key schedule backwards: NR-1 down to 0.
        rk_idx   = dec_r ? (NR_L - cnt_r) : cnt_r;
        rnd_last = (cnt_r == NR_L);
      end
      ST_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // State, shared counter, key-valid flag, mode latch and block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      key_ok_r  <= 1'b0;
      dec_r     <= 1'b0;
      blk_cnt_r <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (key_start) begin
            state_r  <= ST_KEXP;
            cnt_r    <= 4'd1;
            key_ok_r <= 1'b0;
          end else if (accept) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd1;
            dec_r   <= in_decrypt;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_KEXP: begin
          if (cnt_r == NR_L) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            key_ok_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RUN: begin
          if (cnt_r == NR_L) begin
            state_r <= ST_DONE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
            if (blk_cnt_r != {CNTW{1'b1}}) begin
              blk_cnt_r <= blk_cnt_r + CNTW'(1);
            end else begin
              blk_cnt_r <= blk_cnt_r;
            end
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule
